// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-style controller: FSM states,
// primary opcodes and the datapath mux/ALU select codes.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_op_class.sv
// Combinational opcode classifier; optional instructions are gated by
// parameters so a disabled opcode falls through to illegal.
module mc_op_class
    import mc_ctrl_pkg::*;
#(
    parameter bit HAS_ADDI = 1'b1,
    parameter bit HAS_JUMP = 1'b1
) (
    input  logic [5:0] i_opcode,
    output logic       o_is_lw,
    output logic       o_is_sw,
    output logic       o_is_rtype,
    output logic       o_is_beq,
    output logic       o_is_addi,
    output logic       o_is_j,
    output logic       o_is_illegal
);

    assign o_is_lw      = (i_opcode == OP_LW);
    assign o_is_sw      = (i_opcode == OP_SW);
    assign o_is_rtype   = (i_opcode == OP_RTYPE);
    assign o_is_beq     = (i_opcode == OP_BEQ);
    assign o_is_addi    = HAS_ADDI && (i_opcode == OP_ADDI);
    assign o_is_j       = HAS_JUMP && (i_opcode == OP_J);
    assign o_is_illegal = !(o_is_lw || o_is_sw || o_is_rtype || o_is_beq ||
                            o_is_addi || o_is_j);

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle controller FSM: sequences fetch/decode/execute/memory/writeback
// and drives the datapath selects and write enables for each state.
module multicycle_controller
    import mc_ctrl_pkg::*;
#(
    parameter bit HAS_ADDI = 1'b1,
    parameter bit HAS_JUMP = 1'b1,
    parameter bit MEM_WAIT = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       branch,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_t     r_state;
    state_t     w_next;
    logic [5:0] r_op_held;
    logic       w_ready;
    logic       w_is_lw, w_is_sw, w_is_rtype, w_is_beq, w_is_addi, w_is_j, w_is_illegal;

    assign w_ready = MEM_WAIT ? mem_ready : 1'b1;
    assign state   = r_state;

    mc_op_class #(
        .HAS_ADDI (HAS_ADDI),
        .HAS_JUMP (HAS_JUMP)
    ) u_op_class (
        .i_opcode     (opcode),
        .o_is_lw      (w_is_lw),
        .o_is_sw      (w_is_sw),
        .o_is_rtype   (w_is_rtype),
        .o_is_beq     (w_is_beq),
        .o_is_addi    (w_is_addi),
        .o_is_j       (w_is_j),
        .o_is_illegal (w_is_illegal)
    );

    // The opcode is only valid on the bus during DECODE, so MEMADR relies on this copy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_op_held <= 6'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_op_held <= opcode;
            end
        end
    end

    always_comb begin
        w_next     = S_FETCH;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        branch     = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_B;
        alu_op     = ALU_ADD;
        pc_src     = PC_ALU;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        case (r_state)
            S_FETCH: begin
                alu_src_b = SRCB_FOUR;
                ir_write  = w_ready;
                pc_write  = w_ready;
                w_next    = w_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b  = SRCB_IMM_SH;
                illegal_op = w_is_illegal;
                if (w_is_lw || w_is_sw) w_next = S_MEMADR;
                else if (w_is_rtype)    w_next = S_EXECUTE;
                else if (w_is_beq)      w_next = S_BRANCH;
                else if (w_is_addi)     w_next = S_ADDIEX;
                else if (w_is_j)        w_next = S_JUMP;
                else                    w_next = S_FETCH;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                if (r_op_held == OP_LW)      w_next = S_MEMRD;
                else if (r_op_held == OP_SW) w_next = S_MEMWR;
                else                         w_next = S_FETCH;
            end
            S_MEMRD: begin
                iord   = 1'b1;
                w_next = w_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                mem_write  = 1'b1;
                instr_done = w_ready;
                w_next     = w_ready ? S_FETCH : S_MEMWR;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = ALU_SUB;
                pc_src     = PC_ALUOUT;
                branch     = 1'b1;
                instr_done = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                w_next    = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pc_src     = PC_JUMP;
                pc_write   = 1'b1;
                instr_done = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase

        // Side-effecting strobes must stay quiet for the whole reset cycle.
        if (!rst_n) begin
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            branch     = 1'b0;
            instr_done = 1'b0;
            illegal_op = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized scoreboard bench for multicycle_controller: a default instance and
// a reduced instance (no addi, no j, no memory wait) checked cycle by cycle.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n_a, rst_n_b, mem_ready;
    logic [5:0] opcode;

    logic       a_iord, a_irw, a_pcw, a_memw, a_regw, a_br, a_srca, a_rdst, a_m2r, a_done, a_ill;
    logic [1:0] a_srcb, a_aop, a_pcs;
    logic [3:0] a_st;
    logic       b_iord, b_irw, b_pcw, b_memw, b_regw, b_br, b_srca, b_rdst, b_m2r, b_done, b_ill;
    logic [1:0] b_srcb, b_aop, b_pcs;
    logic [3:0] b_st;

    always #5 clk = ~clk;

    multicycle_controller u_dut (
        .clk(clk), .rst_n(rst_n_a), .opcode(opcode), .mem_ready(mem_ready),
        .iord(a_iord), .ir_write(a_irw), .pc_write(a_pcw), .mem_write(a_memw),
        .reg_write(a_regw), .branch(a_br), .alu_src_a(a_srca), .alu_src_b(a_srcb),
        .alu_op(a_aop), .pc_src(a_pcs), .reg_dst(a_rdst), .mem_to_reg(a_m2r),
        .instr_done(a_done), .illegal_op(a_ill), .state(a_st)
    );

    multicycle_controller #(.HAS_ADDI(1'b0), .HAS_JUMP(1'b0), .MEM_WAIT(1'b0)) u_dut_min (
        .clk(clk), .rst_n(rst_n_b), .opcode(opcode), .mem_ready(mem_ready),
        .iord(b_iord), .ir_write(b_irw), .pc_write(b_pcw), .mem_write(b_memw),
        .reg_write(b_regw), .branch(b_br), .alu_src_a(b_srca), .alu_src_b(b_srcb),
        .alu_op(b_aop), .pc_src(b_pcs), .reg_dst(b_rdst), .mem_to_reg(b_m2r),
        .instr_done(b_done), .illegal_op(b_ill), .state(b_st)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       iord, irw, pcw, memw, regw, br, srca;
        logic [1:0] srcb, aop, pcs;
        logic       rdst, m2r, done, ill;
    } exp_t;

    exp_t exp_q[$];
    bit   sel_q[$];
    bit   sel;
    int   total = 0;
    int   bad   = 0;
    int   ci, rst_at;
    bit   aborted;

    function automatic exp_t mk(input int st);
        exp_t e;
        e    = '0;
        e.st = st[3:0];
        return e;
    endfunction

    function automatic logic [5:0] rnd_op();
        return 6'($urandom);
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom);
    endfunction

    // One clock of stimulus; the expected view of that cycle goes to the scoreboard.
    task automatic cyc(input exp_t e_in, input logic mr, input logic [5:0] op, input logic rn);
        exp_t e;
        e = e_in;
        @(posedge clk);
        #1;
        mem_ready = mr;
        opcode    = op;
        if (sel) begin
            rst_n_b = rn;
            rst_n_a = 1'b0;
        end else begin
            rst_n_a = rn;
            rst_n_b = 1'b0;
        end
        if (!rn) begin
            e.irw = 1'b0; e.pcw = 1'b0; e.memw = 1'b0; e.regw = 1'b0;
            e.br = 1'b0; e.done = 1'b0; e.ill = 1'b0;
        end
        exp_q.push_back(e);
        sel_q.push_back(sel);
    endtask

    task automatic step(input exp_t e, input logic mr, input logic [5:0] op);
        logic rn;
        if (aborted) return;
        rn = (ci == rst_at) ? 1'b0 : 1'b1;
        ci++;
        cyc(e, mr, op, rn);
        if (!rn) aborted = 1'b1;
    endtask

    task automatic reset_cyc();
        exp_t e;
        e = mk(0);
        e.srcb = 2'b01;
        cyc(e, rnd_bit(), rnd_op(), 1'b0);
    endtask

    // Reference: expand one instruction into its per-cycle expectations.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input int ra);
        exp_t e;
        bit   lw, sw, rt, bq, ad, jp;
        int   nf, nm;
        logic rdy;
        ci = 0; rst_at = ra; aborted = 1'b0;
        nf = sel ? 0 : fw;
        nm = sel ? 0 : mw;
        lw = (op == 6'b100011);
        sw = (op == 6'b101011);
        rt = (op == 6'b000000);
        bq = (op == 6'b000100);
        ad = (op == 6'b001000) && !sel;
        jp = (op == 6'b000010) && !sel;

        for (int i = 0; i < nf; i++) begin
            e = mk(0); e.srcb = 2'b01;
            step(e, 1'b0, rnd_op());
        end
        rdy = sel ? rnd_bit() : 1'b1;
        e = mk(0); e.srcb = 2'b01; e.irw = 1'b1; e.pcw = 1'b1;
        step(e, rdy, rnd_op());

        e = mk(1); e.srcb = 2'b11; e.ill = !(lw | sw | rt | bq | ad | jp);
        step(e, rnd_bit(), op);

        if (lw || sw) begin
            e = mk(2); e.srca = 1'b1; e.srcb = 2'b10;
            step(e, rnd_bit(), rnd_op());
            if (lw) begin
                for (int i = 0; i < nm; i++) begin
                    e = mk(3); e.iord = 1'b1;
                    step(e, 1'b0, rnd_op());
                end
                rdy = sel ? rnd_bit() : 1'b1;
                e = mk(3); e.iord = 1'b1;
                step(e, rdy, rnd_op());
                e = mk(4); e.regw = 1'b1; e.m2r = 1'b1; e.done = 1'b1;
                step(e, rnd_bit(), rnd_op());
            end else begin
                for (int i = 0; i < nm; i++) begin
                    e = mk(5); e.iord = 1'b1; e.memw = 1'b1;
                    step(e, 1'b0, rnd_op());
                end
                rdy = sel ? rnd_bit() : 1'b1;
                e = mk(5); e.iord = 1'b1; e.memw = 1'b1; e.done = 1'b1;
                step(e, rdy, rnd_op());
            end
        end else if (rt) begin
            e = mk(6); e.srca = 1'b1; e.aop = 2'b10;
            step(e, rnd_bit(), rnd_op());
            e = mk(7); e.regw = 1'b1; e.rdst = 1'b1; e.done = 1'b1;
            step(e, rnd_bit(), rnd_op());
        end else if (bq) begin
            e = mk(8); e.srca = 1'b1; e.aop = 2'b01; e.pcs = 2'b01; e.br = 1'b1; e.done = 1'b1;
            step(e, rnd_bit(), rnd_op());
        end else if (ad) begin
            e = mk(9); e.srca = 1'b1; e.srcb = 2'b10;
            step(e, rnd_bit(), rnd_op());
            e = mk(10); e.regw = 1'b1; e.done = 1'b1;
            step(e, rnd_bit(), rnd_op());
        end else if (jp) begin
            e = mk(11); e.pcs = 2'b10; e.pcw = 1'b1; e.done = 1'b1;
            step(e, rnd_bit(), rnd_op());
        end
    endtask

    always @(negedge clk) begin
        exp_t e, act;
        bit   s;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            s = sel_q.pop_front();
            if (s)
                act = {b_st, b_iord, b_irw, b_pcw, b_memw, b_regw, b_br, b_srca,
                       b_srcb, b_aop, b_pcs, b_rdst, b_m2r, b_done, b_ill};
            else
                act = {a_st, a_iord, a_irw, a_pcw, a_memw, a_regw, a_br, a_srca,
                       a_srcb, a_aop, a_pcs, a_rdst, a_m2r, a_done, a_ill};
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL cycle dut=%0d t=%0t actual=%h required=%h (state %0d vs %0d)",
                         s, $time, act, e, act.st, e.st);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ops [6];
        logic [5:0] op;
        int         ra;
        ops[0] = 6'b100011; ops[1] = 6'b101011; ops[2] = 6'b000000;
        ops[3] = 6'b000100; ops[4] = 6'b001000; ops[5] = 6'b000010;
        rst_n_a = 1'b0; rst_n_b = 1'b0; mem_ready = 1'b0; opcode = 6'd0; sel = 1'b0;

        repeat (2) reset_cyc();
        run_instr(6'b100011, 0, 0, -1);
        run_instr(6'b101011, 0, 3, -1);
        run_instr(6'b000000, 2, 0, -1);
        run_instr(6'b111111, 0, 0, -1);
        run_instr(6'b000100, 1, 0, -1);
        run_instr(6'b000010, 0, 0, -1);
        run_instr(6'b001000, 0, 0, -1);
        run_instr(6'b000000, 0, 0, 2);
        run_instr(6'b100011, 1, 1, -1);
        run_instr(6'b101011, 0, 3, 4);
        run_instr(6'b100011, 2, 2, 1);
        run_instr(6'b000100, 0, 0, -1);

        for (int n = 0; n < 80; n++) begin
            int k;
            k  = $urandom_range(0, 7);
            op = (k < 6) ? ops[k] : rnd_op();
            ra = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 6) : -1;
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 2), ra);
        end

        sel = 1'b1;
        reset_cyc();
        run_instr(6'b001000, 0, 0, -1);
        run_instr(6'b000010, 0, 0, -1);
        run_instr(6'b100011, 2, 2, -1);
        run_instr(6'b101011, 1, 3, -1);
        run_instr(6'b000000, 0, 0, -1);
        run_instr(6'b000100, 0, 0, -1);
        run_instr(6'b111111, 0, 0, -1);
        for (int n = 0; n < 20; n++) begin
            int k;
            k  = $urandom_range(0, 7);
            op = (k < 6) ? ops[k] : rnd_op();
            run_instr(op, 0, 0, -1);
        end

        repeat (3) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: pending=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
